rf_read_stage: RTL and testbench

// - Register-read stage of the 16-bit, 4-stage CPU pipeline (fetch -> rf_read -> execute -> writeback).
// - Decodes Rx/Ry, reads an internal 8x16 register file and applies forwarding selects from the hazard detector.
// - Inserts a one-cycle bubble on load-use hazards.
// - Registers instruction, PC and operands into the execute-stage pipeline register under stall/flush control.

---
 rtl/rf_read_stage_if.sv | 44 ++++
 rtl/rf_read_stage.sv | 103 ++++++++++
 tb/tb_rf_read_stage.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_read_stage_if.sv
// Bundle of every signal between the register-read stage and its neighbours:
// fetch, execute, writeback and the hazard detector.
// The master modport drives the i_* side and the slave modport (the stage itself)
// drives the o_* side.
interface rf_read_stage_if #(
   parameter int DW = 16,
   parameter int AW = 3
);
   // from fetch
   logic          i_valid;
   logic [DW-1:0] i_ir;
   logic [DW-1:0] i_pc;
   // from execute / branch resolution
   logic          i_stall;
   logic          i_flush;
   logic          i_ex_valid;
   logic [DW-1:0] i_ex_ir;
   // from writeback
   logic          i_wb_en;
   logic [AW-1:0] i_wb_addr;
   logic [DW-1:0] i_wb_data;
   // from hazard detector
   logic [1:0]    i_fwd_sel;
   logic [DW-1:0] i_fwd_data;
   // execute-stage pipeline register and fetch hold request
   logic          o_valid;
   logic [DW-1:0] o_ir;
   logic [DW-1:0] o_pc;
   logic [DW-1:0] o_rx_val;
   logic [DW-1:0] o_ry_val;
   logic          o_stall;

   modport master (
      output i_valid, i_ir, i_pc, i_stall, i_flush, i_ex_valid, i_ex_ir,
             i_wb_en, i_wb_addr, i_wb_data, i_fwd_sel, i_fwd_data,
      input  o_valid, o_ir, o_pc, o_rx_val, o_ry_val, o_stall
   );

   modport slave (
      input  i_valid, i_ir, i_pc, i_stall, i_flush, i_ex_valid, i_ex_ir,
             i_wb_en, i_wb_addr, i_wb_data, i_fwd_sel, i_fwd_data,
      output o_valid, o_ir, o_pc, o_rx_val, o_ry_val, o_stall
   );
endinterface

// File: rtl/rf_read_stage.sv
// Register-read stage of the 4-stage 16-bit pipeline.
// Decodes Rx/Ry, reads the 8x16 register file (with write-through from writeback),
// applies operand forwarding, inserts a one-cycle bubble on load-use hazards and
// registers the instruction, PC and operands for execute.
// Instruction layout: [3:0] opcode, [4] imm flag, [7:5] Rx, [10:8] Ry.
module rf_read_stage #(
   parameter int         NREGS = 8,
   parameter int         DW    = 16,
   parameter logic [3:0] OP_LD = 4'd8   // load opcode, must match the ISA opcode table
) (
   input logic           clk,
   input logic           rst,
   rf_read_stage_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   typedef enum logic {RUN, BUBBLE} state_t;

   state_t        state;
   logic [DW-1:0] regs [NREGS];

   logic [AW-1:0] rx_addr;
   logic [AW-1:0] ry_addr;
   logic [AW-1:0] ex_rx_addr;
   logic [DW-1:0] rx_val;
   logic [DW-1:0] ry_val;
   logic          ex_is_load;
   logic          hazard;
   logic          unused_ex_bits;

   assign rx_addr    = bus.i_ir[5 +: AW];
   assign ry_addr    = bus.i_ir[8 +: AW];
   assign ex_rx_addr = bus.i_ex_ir[5 +: AW];

   // Only the opcode and Rx of the execute instruction matter for load-use detection.
   assign unused_ex_bits = ^{bus.i_ex_ir[DW-1:8], bus.i_ex_ir[4]};

   // Operand select: forwarding beats the same-cycle writeback, which beats the array.
   always_comb begin
      rx_val = regs[rx_addr];
      if (bus.i_fwd_sel[0])
         rx_val = bus.i_fwd_data;
      else if (bus.i_wb_en && (bus.i_wb_addr == rx_addr))
         rx_val = bus.i_wb_data;

      ry_val = regs[ry_addr];
      if (bus.i_fwd_sel[1])
         ry_val = bus.i_fwd_data;
      else if (bus.i_wb_en && (bus.i_wb_addr == ry_addr))
         ry_val = bus.i_wb_data;
   end

   // Load-use: a load in execute whose destination (its Rx) is a source here.
   // Ry is only a source when the instruction is not in immediate form.
   always_comb begin
      ex_is_load = bus.i_ex_valid && (bus.i_ex_ir[3:0] == OP_LD);
      hazard     = bus.i_valid && ex_is_load &&
                   ((ex_rx_addr == rx_addr) ||
                    (!bus.i_ir[4] && (ex_rx_addr == ry_addr)));
   end

   // Fetch must hold while execute stalls or while the bubble is being inserted.
   assign bus.o_stall = bus.i_stall || ((state == RUN) && hazard);

   // Register file: every register cleared on reset, written from writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (bus.i_wb_en) begin
         regs[bus.i_wb_addr] <= bus.i_wb_data;
      end
   end

   // Bubble FSM and execute-stage pipeline register.
   // The bubble state lasts exactly one cycle; in it the held instruction is
   // loaded even though the hazard inputs may still look active.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RUN;
         bus.o_valid  <= 1'b0;
         bus.o_ir     <= '0;
         bus.o_pc     <= '0;
         bus.o_rx_val <= '0;
         bus.o_ry_val <= '0;
      end else if (bus.i_flush) begin
         state       <= RUN;
         bus.o_valid <= 1'b0;
      end else if (bus.i_stall) begin
         state <= RUN;
      end else if ((state == RUN) && hazard) begin
         state       <= BUBBLE;
         bus.o_valid <= 1'b0;
      end else begin
         state        <= RUN;
         bus.o_valid  <= bus.i_valid;
         bus.o_ir     <= bus.i_ir;
         bus.o_pc     <= bus.i_pc;
         bus.o_rx_val <= rx_val;
         bus.o_ry_val <= ry_val;
      end
   end
endmodule

// File: tb/tb_rf_read_stage.sv
// Self-checking bench for rf_read_stage: directed scenarios plus a randomized run
// against a behavioural model (register array, expected output register, bubble flag).
module tb_rf_read_stage;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_MV  = 4'd3;
   localparam logic [3:0] OP_LD  = 4'd8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   rf_read_stage_if #(.DW(16), .AW(3)) bus ();

   rf_read_stage #(.NREGS(8), .DW(16), .OP_LD(OP_LD)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [15:0] m_regs [8];
   bit          m_bubble;
   logic        exp_valid;
   logic [15:0] exp_ir, exp_pc, exp_rx, exp_ry;

   function automatic logic [15:0] mk(input logic [3:0] op, input logic imm,
                                      input logic [2:0] rx, input logic [2:0] ry);
      return {5'b0, ry, rx, imm, op};
   endfunction

   function automatic logic [15:0] ref_operand(input logic [2:0] a, input logic fwd);
      if (fwd) return bus.i_fwd_data;
      if (bus.i_wb_en && bus.i_wb_addr == a) return bus.i_wb_data;
      return m_regs[a];
   endfunction

   function automatic bit ref_hazard();
      logic [2:0] ld_dst;
      ld_dst = bus.i_ex_ir[7:5];
      if (!(bus.i_valid && bus.i_ex_valid && bus.i_ex_ir[3:0] == OP_LD)) return 1'b0;
      if (ld_dst == bus.i_ir[7:5]) return 1'b1;
      if (!bus.i_ir[4] && ld_dst == bus.i_ir[10:8]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit ref_stall();
      return bus.i_stall || (!m_bubble && ref_hazard());
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_bubble  = 0;
      exp_valid = 0;
      exp_ir = '0; exp_pc = '0; exp_rx = '0; exp_ry = '0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      logic [15:0] rx, ry;
      bit hz;
      hz = ref_hazard();
      rx = ref_operand(bus.i_ir[7:5], bus.i_fwd_sel[0]);
      ry = ref_operand(bus.i_ir[10:8], bus.i_fwd_sel[1]);
      if (bus.i_flush) begin
         exp_valid = 0; m_bubble = 0;
      end else if (bus.i_stall) begin
         m_bubble = 0;
      end else if (!m_bubble && hz) begin
         exp_valid = 0; m_bubble = 1;
      end else begin
         exp_valid = bus.i_valid; exp_ir = bus.i_ir; exp_pc = bus.i_pc;
         exp_rx = rx; exp_ry = ry; m_bubble = 0;
      end
      if (bus.i_wb_en) m_regs[bus.i_wb_addr] = bus.i_wb_data;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.i_valid = 0; bus.i_ir = '0; bus.i_pc = '0;
      bus.i_stall = 0; bus.i_flush = 0;
      bus.i_wb_en = 0; bus.i_wb_addr = '0; bus.i_wb_data = '0;
      bus.i_fwd_sel = '0; bus.i_fwd_data = '0;
      bus.i_ex_valid = 0; bus.i_ex_ir = '0;
   endtask

   task automatic issue(input logic [15:0] ir, input logic [15:0] pc);
      bus.i_valid = 1; bus.i_ir = ir; bus.i_pc = pc;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle();
      rst = 1;
      m_reset();
      #2;
      checks++;
      if ({bus.o_valid, bus.o_ir, bus.o_pc, bus.o_rx_val, bus.o_ry_val} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got v=%0b ir=%h pc=%h rx=%h ry=%h required all 0",
                  bus.o_valid, bus.o_ir, bus.o_pc, bus.o_rx_val, bus.o_ry_val);
      end
      checks++;
      if (bus.o_stall !== 1'b0) begin
         errors++; $display("FAIL reset_stall got %b required 0", bus.o_stall);
      end
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      $display("reset: outputs cleared");
   endtask

   task automatic test_wb_read();
      idle();
      bus.i_wb_en = 1; bus.i_wb_addr = 3'd3; bus.i_wb_data = 16'h1234;
      tick();
      idle();
      issue(mk(OP_ADD, 0, 3'd1, 3'd3), 16'h0010);
      tick();
      checks++;
      if (bus.o_ry_val !== 16'h1234 || bus.o_valid !== 1'b1) begin
         errors++;
         $display("FAIL wb_read got ry=%h v=%b required ry=1234 v=1", bus.o_ry_val, bus.o_valid);
      end
      checks++;
      if (bus.o_ir !== mk(OP_ADD, 0, 3'd1, 3'd3) || bus.o_pc !== 16'h0010) begin
         errors++; $display("FAIL wb_read_ir got ir=%h pc=%h required ir=%h pc=0010",
                            bus.o_ir, bus.o_pc, mk(OP_ADD, 0, 3'd1, 3'd3));
      end
      $display("wb_read: ADD R1,R3 ry=%h", bus.o_ry_val);
   endtask

   task automatic test_bypass();
      idle();
      issue(mk(OP_ADD, 0, 3'd2, 3'd0), 16'h0011);
      bus.i_wb_en = 1; bus.i_wb_addr = 3'd2; bus.i_wb_data = 16'hBEEF;
      tick();
      checks++;
      if (bus.o_rx_val !== 16'hBEEF) begin
         errors++; $display("FAIL bypass got rx=%h required BEEF", bus.o_rx_val);
      end
      $display("bypass: rx=%h", bus.o_rx_val);
   endtask

   task automatic test_forward();
      idle();
      bus.i_wb_en = 1; bus.i_wb_addr = 3'd5; bus.i_wb_data = 16'h5555;
      tick();
      idle();
      issue(mk(OP_ADD, 0, 3'd5, 3'd5), 16'h0012);
      bus.i_fwd_sel = 2'b01; bus.i_fwd_data = 16'h00AA;
      tick();
      checks++;
      if (bus.o_rx_val !== 16'h00AA || bus.o_ry_val !== 16'h5555) begin
         errors++; $display("FAIL forward got rx=%h ry=%h required rx=00AA ry=5555",
                            bus.o_rx_val, bus.o_ry_val);
      end
      $display("forward: rx=%h ry=%h", bus.o_rx_val, bus.o_ry_val);
   endtask

   task automatic test_load_use();
      idle();
      issue(mk(OP_SUB, 0, 3'd4, 3'd1), 16'h0020);
      bus.i_ex_valid = 1; bus.i_ex_ir = mk(OP_LD, 0, 3'd4, 3'd0);
      #1;
      checks++;
      if (bus.o_stall !== 1'b1) begin
         errors++; $display("FAIL load_use_stall got %b required 1", bus.o_stall);
      end
      tick();
      checks++;
      if (bus.o_valid !== 1'b0) begin
         errors++; $display("FAIL load_use_bubble got v=%b required 0", bus.o_valid);
      end
      // Bubble cycle: load result forwarded; hazard inputs still look active.
      bus.i_fwd_sel = 2'b01; bus.i_fwd_data = 16'hCAFE;
      #1;
      checks++;
      if (bus.o_stall !== 1'b0) begin
         errors++; $display("FAIL load_use_release got stall=%b required 0", bus.o_stall);
      end
      tick();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_ir !== mk(OP_SUB, 0, 3'd4, 3'd1) || bus.o_rx_val !== 16'hCAFE) begin
         errors++; $display("FAIL load_use_issue got v=%b ir=%h rx=%h required v=1 ir=%h rx=CAFE",
                            bus.o_valid, bus.o_ir, bus.o_rx_val, mk(OP_SUB, 0, 3'd4, 3'd1));
      end
      $display("load_use: SUB issued after bubble rx=%h", bus.o_rx_val);
   endtask

   task automatic test_stall_flush();
      logic [15:0] held_ir, held_rx;
      idle();
      issue(mk(OP_ADD, 0, 3'd3, 3'd2), 16'h0030);
      tick();
      held_ir = exp_ir; held_rx = exp_rx;
      for (int c = 0; c < 3; c++) begin
         issue(16'($urandom), 16'($urandom));
         bus.i_stall = 1;
         #1;
         checks++;
         if (bus.o_stall !== 1'b1) begin
            errors++; $display("FAIL stall_out cycle %0d got %b required 1", c, bus.o_stall);
         end
         tick();
         checks++;
         if (bus.o_ir !== held_ir || bus.o_rx_val !== held_rx || bus.o_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold cycle %0d got ir=%h rx=%h v=%b required ir=%h rx=%h v=1",
                               c, bus.o_ir, bus.o_rx_val, bus.o_valid, held_ir, held_rx);
         end
      end
      bus.i_flush = 1;
      tick();
      checks++;
      if (bus.o_valid !== 1'b0) begin
         errors++; $display("FAIL stall_flush got v=%b required 0", bus.o_valid);
      end
      $display("stall_flush: held 3 cycles then flushed");
   endtask

   task automatic test_flush_hazard();
      idle();
      issue(mk(OP_ADD, 1, 3'd6, 3'd0), 16'h0040);
      bus.i_ex_valid = 1; bus.i_ex_ir = mk(OP_LD, 0, 3'd6, 3'd2);
      bus.i_flush = 1;
      tick();
      checks++;
      if (bus.o_valid !== 1'b0) begin
         errors++; $display("FAIL flush_hazard_valid got %b required 0", bus.o_valid);
      end
      // Still RUN after the flush, so the persisting hazard must stall again.
      bus.i_flush = 0;
      #1;
      checks++;
      if (bus.o_stall !== 1'b1) begin
         errors++; $display("FAIL flush_hazard_run got stall=%b required 1", bus.o_stall);
      end
      tick();
      tick();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_ir !== mk(OP_ADD, 1, 3'd6, 3'd0)) begin
         errors++; $display("FAIL flush_hazard_issue got v=%b ir=%h required v=1 ir=%h",
                            bus.o_valid, bus.o_ir, mk(OP_ADD, 1, 3'd6, 3'd0));
      end
      $display("flush_hazard: no bubble entered on flush");
   endtask

   task automatic test_random();
      for (int n = 0; n < 200; n++) begin
         logic [2:0] a, b;
         a = 3'($urandom); b = 3'($urandom);
         bus.i_valid    = ($urandom_range(0, 9) != 0);
         bus.i_ir       = {5'($urandom), b, a, 1'($urandom), 4'($urandom)};
         bus.i_pc       = 16'($urandom);
         bus.i_stall    = ($urandom_range(0, 7) == 0);
         bus.i_flush    = ($urandom_range(0, 11) == 0);
         bus.i_wb_en    = 1'($urandom);
         bus.i_wb_addr  = ($urandom_range(0, 3) == 0) ? a : 3'($urandom);
         bus.i_wb_data  = 16'($urandom);
         bus.i_fwd_sel  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
         bus.i_fwd_data = 16'($urandom);
         bus.i_ex_valid = 1'($urandom);
         bus.i_ex_ir    = ($urandom_range(0, 2) == 0)
                          ? {8'($urandom), ($urandom_range(0, 1) != 0) ? a : b, 1'($urandom), OP_LD}
                          : 16'($urandom);
         #1;
         checks++;
         if (bus.o_stall !== ref_stall()) begin
            errors++; $display("FAIL rand_stall n=%0d got %b required %b", n, bus.o_stall, ref_stall());
         end
         tick();
         checks++;
         if (bus.o_valid !== exp_valid || bus.o_ir !== exp_ir || bus.o_pc !== exp_pc ||
             bus.o_rx_val !== exp_rx || bus.o_ry_val !== exp_ry) begin
            errors++;
            $display("FAIL rand_out n=%0d got v=%b ir=%h pc=%h rx=%h ry=%h required v=%b ir=%h pc=%h rx=%h ry=%h",
                     n, bus.o_valid, bus.o_ir, bus.o_pc, bus.o_rx_val, bus.o_ry_val,
                     exp_valid, exp_ir, exp_pc, exp_rx, exp_ry);
         end
         $display("rand %0d: v=%b ir=%h rx=%h ry=%h", n, bus.o_valid, bus.o_ir, bus.o_rx_val, bus.o_ry_val);
      end
   endtask

   task automatic test_reset_in_bubble();
      idle();
      bus.i_wb_en = 1; bus.i_wb_addr = 3'd7; bus.i_wb_data = 16'h7777;
      tick();
      idle();
      issue(mk(OP_ADD, 0, 3'd2, 3'd3), 16'h0050);
      bus.i_ex_valid = 1; bus.i_ex_ir = mk(OP_LD, 0, 3'd3, 3'd0);
      tick();                      // now in the bubble cycle
      #2;
      rst = 1;
      m_reset();
      #1;
      checks++;
      if ({bus.o_valid, bus.o_ir, bus.o_pc, bus.o_rx_val, bus.o_ry_val} !== '0) begin
         errors++;
         $display("FAIL bubble_reset got v=%0b ir=%h pc=%h rx=%h ry=%h required all 0",
                  bus.o_valid, bus.o_ir, bus.o_pc, bus.o_rx_val, bus.o_ry_val);
      end
      idle();
      @(negedge clk); rst = 0;
      issue(mk(OP_MV, 1, 3'd0, 3'd7), 16'h0007);
      tick();
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_ir !== mk(OP_MV, 1, 3'd0, 3'd7) ||
          bus.o_rx_val !== 16'h0 || bus.o_ry_val !== 16'h0) begin
         errors++; $display("FAIL bubble_reset_mv got v=%b ir=%h rx=%h ry=%h required v=1 ir=%h rx=0 ry=0",
                            bus.o_valid, bus.o_ir, bus.o_rx_val, bus.o_ry_val, mk(OP_MV, 1, 3'd0, 3'd7));
      end
      $display("reset_in_bubble: MV R0,#7 flowed ir=%h", bus.o_ir);
   endtask

   initial begin
      test_reset();
      test_wb_read();
      test_bypass();
      test_forward();
      test_load_use();
      test_stall_flush();
      test_flush_hazard();
      test_random();
      test_reset_in_bubble();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
